seven_seg_scan_ctrl: RTL

Time-multiplexing controller for a multi-digit common-anode 7-segment display. It shares one registered Binary_To_7seg decoder across NUM_DIGITS digits. Each scan slot drives the decoder's 4-bit input with the current digit's nibble and sequences the active-low digit enables. A blanking guard time before each slot covers the decoder's 1-cycle latency and suppresses ghosting. New display values are double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/seven_seg_scan_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// One shared registered decoder is fed a nibble per slot; each slot is a
// dark guard interval followed by the lit interval. New values are
// double-buffered and committed only at frame boundaries.
//
// state | meaning
// IDLE  | no value loaded yet since reset, display dark
// BLANK | guard time, all anodes dark, nibble for upcoming digit presented
// ON    | current digit lit (if enabled), nibble held stable
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLKS_PER_DIGIT = 25000,
    parameter int BLANK_CLKS     = 250
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic [NUM_DIGITS-1:0]   i_digit_en,
    output logic [3:0]              o_nibble,
    output logic [NUM_DIGITS-1:0]   o_anode_n,
    output logic                    o_frame_done,
    output logic                    o_pending
);

    localparam int MAX_CLKS = (BLANK_CLKS > CLKS_PER_DIGIT) ? BLANK_CLKS : CLKS_PER_DIGIT;
    localparam int CNT_W    = $clog2(MAX_CLKS);
    localparam int IDX_W    = $clog2(NUM_DIGITS);
    localparam int VAL_W    = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CLKS - 1);
    localparam logic [CNT_W-1:0] ON_LOAD    = CNT_W'(CLKS_PER_DIGIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [IDX_W-1:0]        idx_q;
    logic [VAL_W-1:0]        act_val_q;
    logic [NUM_DIGITS-1:0]   act_en_q;
    logic [VAL_W-1:0]        shd_val_q;
    logic [NUM_DIGITS-1:0]   shd_en_q;
    logic                    pending_q;
    logic [3:0]              nibble_q;
    logic [NUM_DIGITS-1:0]   anode_n_q;
    logic                    frame_done_q;

    logic                    last_cnt;
    logic                    boundary;
    logic [IDX_W-1:0]        idx_d;
    logic [VAL_W-1:0]        act_val_d;
    logic [NUM_DIGITS-1:0]   act_en_d;
    logic [3:0]              nibble_d;

    function automatic logic [3:0] pick_nibble(input logic [VAL_W-1:0] v,
                                               input logic [IDX_W-1:0] k);
        logic [3:0] n;
        n = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (k == IDX_W'(i)) n = v[4*i +: 4];
        end
        return n;
    endfunction

    // Only one anode may ever be low; a disabled digit stays dark.
    function automatic logic [NUM_DIGITS-1:0] anode_for(input logic [IDX_W-1:0] k,
                                                        input logic [NUM_DIGITS-1:0] en);
        logic [NUM_DIGITS-1:0] a;
        a = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (k == IDX_W'(i) && en[i]) a[i] = 1'b0;
        end
        return a;
    endfunction

    // Next digit index and the data digit 0 of the next frame will use.
    always_comb begin
        last_cnt  = (cnt_q == '0);
        boundary  = (state_q == ON) && last_cnt && (idx_q == IDX_LAST);
        idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        act_val_d = act_val_q;
        act_en_d  = act_en_q;
        if (boundary && i_load) begin
            act_val_d = i_value;
            act_en_d  = i_digit_en;
        end else if (boundary && pending_q) begin
            act_val_d = shd_val_q;
            act_en_d  = shd_en_q;
        end
        nibble_d = pick_nibble(act_val_d, idx_d);
    end

    // Scan FSM with slot timer, double buffer and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            act_val_q    <= '0;
            act_en_q     <= '0;
            shd_val_q    <= '0;
            shd_en_q     <= '0;
            pending_q    <= 1'b0;
            nibble_q     <= 4'h0;
            anode_n_q    <= '1;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    anode_n_q <= '1;
                    if (i_load) begin
                        act_val_q <= i_value;
                        act_en_q  <= i_digit_en;
                        idx_q     <= '0;
                        nibble_q  <= i_value[3:0];
                        cnt_q     <= BLANK_LOAD;
                        state_q   <= BLANK;
                    end
                end
                BLANK: begin
                    if (last_cnt) begin
                        anode_n_q <= anode_for(idx_q, act_en_q);
                        cnt_q     <= ON_LOAD;
                        state_q   <= ON;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ON: begin
                    if (last_cnt) begin
                        anode_n_q <= '1;
                        idx_q     <= idx_d;
                        nibble_q  <= nibble_d;
                        act_val_q <= act_val_d;
                        act_en_q  <= act_en_d;
                        cnt_q     <= BLANK_LOAD;
                        state_q   <= BLANK;
                        if (boundary) begin
                            frame_done_q <= 1'b1;
                            pending_q    <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    anode_n_q <= '1;
                    state_q   <= IDLE;
                end
            endcase
            // Loads while scanning park in the shadow; latest one wins.
            if (i_load && (state_q != IDLE) && !boundary) begin
                shd_val_q <= i_value;
                shd_en_q  <= i_digit_en;
                pending_q <= 1'b1;
            end
        end
    end

    assign o_nibble     = nibble_q;
    assign o_anode_n    = anode_n_q;
    assign o_frame_done = frame_done_q;
    assign o_pending    = pending_q;

endmodule
